// File: rtl/ordenador_burbuja_pkg.sv
// Shared definitions for the bubble sorter: FSM state encoding, data/counter/index
// widths and the key transform that maps signed bytes onto an unsigned ordering.
package ordenador_burbuja_pkg;

  localparam int unsigned ANCHO_DATO = 8;
  localparam int unsigned ANCHO_CNT  = 6;
  localparam int unsigned ANCHO_IDX  = 3;
  localparam int unsigned MAX_N      = 8;

  typedef logic [ANCHO_DATO-1:0] dato_t;
  typedef logic [ANCHO_CNT-1:0]  cnt_t;
  typedef logic [ANCHO_IDX-1:0]  idx_t;

  typedef enum logic [1:0] {
    CARGA,
    COMPARA,
    ENTREGA
  } estado_t;

  // Flipping the sign bit turns two's-complement order into plain unsigned order,
  // so a single unsigned comparator serves both modes.
  function automatic dato_t a_clave(dato_t v, bit signo);
    return signo ? (v ^ dato_t'(8'h80)) : v;
  endfunction

endpackage

// File: rtl/ordenador_burbuja_if.sv
// Load/deliver handshake bundle for ordenador_burbuja.
//   in_valido/dato_in/in_listo    : producer side, one entry per accepted cycle
//   out_valido/dato_out/ultimo/out_listo : consumer side, sorted entries ascending
// master: the producer/consumer environment; slave: the sorter.
interface ordenador_burbuja_if;
  import ordenador_burbuja_pkg::*;

  logic  in_valido;
  dato_t dato_in;
  logic  in_listo;
  logic  out_valido;
  dato_t dato_out;
  logic  ultimo;
  logic  out_listo;

  modport master (
    output in_valido,
    output dato_in,
    input  in_listo,
    input  out_valido,
    input  dato_out,
    input  ultimo,
    output out_listo
  );

  modport slave (
    input  in_valido,
    input  dato_in,
    output in_listo,
    output out_valido,
    output dato_out,
    output ultimo,
    input  out_listo
  );

endinterface

// File: rtl/comparador8bits.sv
// Unsigned 8-bit magnitude comparator.
//   a, b  : operands
//   igual : a == b, mayor : a > b, menor : a < b
module comparador8bits
  import ordenador_burbuja_pkg::*;
(
  input  dato_t a,
  input  dato_t b,
  output logic  igual,
  output logic  mayor,
  output logic  menor
);

  assign igual = (a == b);
  assign mayor = (a > b);
  assign menor = (a < b);

endmodule

// File: rtl/ordenador_burbuja.sv
// Frame bubble sorter: loads N bytes, sorts them ascending with one compare per
// cycle (early exit on a swap-free pass), then delivers them with a valid/ready
// handshake.
//   clk, rst_n    : clock, asynchronous active-low reset
//   bus           : load/deliver handshake (slave modport)
//   ocupado       : high while sorting
//   comparaciones : compare steps of the current/last frame
//   intercambios  : swaps of the current/last frame
module ordenador_burbuja
  import ordenador_burbuja_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter bit          SIGNO = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ordenador_burbuja_if.slave   bus,
  output logic                 ocupado,
  output cnt_t                 comparaciones,
  output cnt_t                 intercambios
);

  localparam idx_t ULTIMO_IDX   = idx_t'(N - 1);
  localparam idx_t PENULT_IDX   = idx_t'(N - 2);

  estado_t estado;
  idx_t    k, i, j, p;
  logic    hubo_swap;
  dato_t   ent [MAX_N];
  dato_t   ent_sw [MAX_N];

  logic    in_listo_r, out_valido_r, ultimo_r, ocupado_r;
  dato_t   dato_out_r;
  cnt_t    cmp_r, swp_r;

  idx_t    i_sig, j_sig;
  dato_t   op_a, op_b;
  logic    igual, mayor, menor;
  logic    fin_pasada, fin_orden;
  logic    unused_cmp;

  assign i_sig = i + idx_t'(1);
  assign j_sig = j + idx_t'(1);

  assign op_a = a_clave(ent[i], SIGNO);
  assign op_b = a_clave(ent[i_sig], SIGNO);

  comparador8bits u_comparador (
    .a     (op_a),
    .b     (op_b),
    .igual (igual),
    .mayor (mayor),
    .menor (menor)
  );

  assign unused_cmp = igual ^ menor;

  // Entry array after this cycle's compare; strict "mayor" keeps equal entries in place.
  always_comb begin
    ent_sw = ent;
    if (mayor) begin
      ent_sw[i]     = ent[i_sig];
      ent_sw[i_sig] = ent[i];
    end
  end

  assign fin_pasada = (i == PENULT_IDX - p);
  assign fin_orden  = fin_pasada && (!(hubo_swap || mayor) || (p == PENULT_IDX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado       <= CARGA;
      k            <= '0;
      i            <= '0;
      j            <= '0;
      p            <= '0;
      hubo_swap    <= 1'b0;
      in_listo_r   <= 1'b1;
      out_valido_r <= 1'b0;
      ultimo_r     <= 1'b0;
      ocupado_r    <= 1'b0;
      dato_out_r   <= '0;
      cmp_r        <= '0;
      swp_r        <= '0;
      for (int unsigned e = 0; e < MAX_N; e++) begin
        ent[e] <= '0;
      end
    end else begin
      unique case (estado)
        CARGA: begin
          if (bus.in_valido) begin
            ent[k] <= bus.dato_in;
            if (k == ULTIMO_IDX) begin
              estado     <= COMPARA;
              k          <= '0;
              i          <= '0;
              p          <= '0;
              hubo_swap  <= 1'b0;
              cmp_r      <= '0;
              swp_r      <= '0;
              in_listo_r <= 1'b0;
              ocupado_r  <= 1'b1;
            end else begin
              k <= k + idx_t'(1);
            end
          end
        end

        COMPARA: begin
          ent   <= ent_sw;
          cmp_r <= cmp_r + cnt_t'(1);
          if (mayor) begin
            swp_r <= swp_r + cnt_t'(1);
          end
          if (fin_pasada) begin
            if (fin_orden) begin
              estado       <= ENTREGA;
              ocupado_r    <= 1'b0;
              out_valido_r <= 1'b1;
              // Entry 0 may be swapped on this very edge, so take the post-swap value.
              dato_out_r   <= ent_sw[0];
              ultimo_r     <= 1'b0;
              j            <= '0;
            end else begin
              p         <= p + idx_t'(1);
              i         <= '0;
              hubo_swap <= 1'b0;
            end
          end else begin
            i         <= i_sig;
            hubo_swap <= hubo_swap | mayor;
          end
        end

        ENTREGA: begin
          if (bus.out_listo) begin
            if (j == ULTIMO_IDX) begin
              estado       <= CARGA;
              out_valido_r <= 1'b0;
              ultimo_r     <= 1'b0;
              in_listo_r   <= 1'b1;
              k            <= '0;
              j            <= '0;
            end else begin
              j          <= j_sig;
              dato_out_r <= ent[j_sig];
              ultimo_r   <= (j_sig == ULTIMO_IDX);
            end
          end
        end

        default: begin
          estado <= CARGA;
        end
      endcase
    end
  end

  assign bus.in_listo   = in_listo_r;
  assign bus.out_valido = out_valido_r;
  assign bus.dato_out   = dato_out_r;
  assign bus.ultimo     = ultimo_r;
  assign ocupado        = ocupado_r;
  assign comparaciones  = cmp_r;
  assign intercambios   = swp_r;

endmodule

// File: tb/tb_ordenador_burbuja.sv
// Bench for ordenador_burbuja: two instances (unsigned and signed), directed frames
// with literal expectations plus randomized frames checked against a behavioural model.
module tb_ordenador_burbuja;
  import ordenador_burbuja_pkg::*;

  localparam int NT = 4;
  typedef logic [7:0] frame_t [NT];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ordenador_burbuja_if bus0 ();
  ordenador_burbuja_if bus1 ();

  logic       iv   [2];
  logic [7:0] di   [2];
  logic       ol   [2];
  logic       il   [2];
  logic       ov   [2];
  logic       ul   [2];
  logic       oc   [2];
  logic [7:0] dout [2];
  logic [5:0] cmpv [2];
  logic [5:0] swpv [2];

  assign bus0.in_valido = iv[0];
  assign bus0.dato_in   = di[0];
  assign bus0.out_listo = ol[0];
  assign bus1.in_valido = iv[1];
  assign bus1.dato_in   = di[1];
  assign bus1.out_listo = ol[1];
  assign il[0]   = bus0.in_listo;
  assign ov[0]   = bus0.out_valido;
  assign ul[0]   = bus0.ultimo;
  assign dout[0] = bus0.dato_out;
  assign il[1]   = bus1.in_listo;
  assign ov[1]   = bus1.out_valido;
  assign ul[1]   = bus1.ultimo;
  assign dout[1] = bus1.dato_out;

  ordenador_burbuja #(.N(NT), .SIGNO(1'b0)) dut0 (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus0),
    .ocupado       (oc[0]),
    .comparaciones (cmpv[0]),
    .intercambios  (swpv[0])
  );

  ordenador_burbuja #(.N(NT), .SIGNO(1'b1)) dut1 (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus1),
    .ocupado       (oc[1]),
    .comparaciones (cmpv[1]),
    .intercambios  (swpv[1])
  );

  int tests = 0;
  int fails = 0;

  frame_t     exp_s   [2];
  frame_t     got_s   [2];
  int         mon_idx [2];
  bit         hold    [2];
  logic [7:0] prevd   [2];

  function automatic void chk(string nm, int got, int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, got, want);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int clave(logic [7:0] v, bit s);
    if (s && v[7]) return int'(v) - 256;
    return int'(v);
  endfunction

  // Sorted order by rank; swaps = inversion count; passes = 1 + the largest number of
  // bigger elements preceding any element (each pass moves such an element one step),
  // capped at N-1; pass p costs N-1-p compares.
  task automatic model(input frame_t vin, input bit s, output frame_t so,
                       output int nc, output int ns);
    int rank, left, lmax, np;
    ns = 0;
    lmax = 0;
    for (int e = 0; e < NT; e++) begin
      rank = 0;
      left = 0;
      for (int x = 0; x < NT; x++) begin
        if (clave(vin[x], s) < clave(vin[e], s)) rank++;
        if (x < e && clave(vin[x], s) == clave(vin[e], s)) rank++;
        if (x < e && clave(vin[x], s) > clave(vin[e], s)) left++;
      end
      so[rank] = vin[e];
      ns += left;
      if (left > lmax) lmax = left;
    end
    np = (lmax + 1 > NT - 1) ? NT - 1 : lmax + 1;
    nc = 0;
    for (int q = 0; q < np; q++) nc += NT - 1 - q;
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!rst_n) begin
          hold[d] = 1'b0;
        end else begin
          chk("exclusion_listo_valido", int'(il[d] & ov[d]), 0);
          if (hold[d] && ov[d]) chk("dato_estable", int'(dout[d]), int'(prevd[d]));
          if (ov[d] && ol[d]) begin
            if (mon_idx[d] < NT) begin
              chk("dato_out", int'(dout[d]), int'(exp_s[d][mon_idx[d]]));
              chk("ultimo", int'(ul[d]), int'(mon_idx[d] == NT - 1));
              got_s[d][mon_idx[d]] = dout[d];
            end else begin
              chk("entrega_extra", mon_idx[d] + 1, NT);
            end
            mon_idx[d]++;
          end
          hold[d]  = ov[d] && !ol[d];
          prevd[d] = dout[d];
        end
      end
    end
  endtask

  task automatic run_frame(input int d, input frame_t vin, input bit s, input bit stall,
                           input bit has_lit, input frame_t lit, input int lc, input int ls);
    frame_t so;
    int nc, ns, n;
    bit stalled;
    logic [7:0] v;
    model(vin, s, so, nc, ns);
    exp_s[d]   = so;
    mon_idx[d] = 0;
    chk("carga_in_listo", int'(il[d]), 1);
    for (int e = 0; e < NT; e++) begin
      iv[d] = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
      iv[d] = 1'b1;
      di[d] = vin[e];
      tick();
    end
    iv[d] = 1'b0;
    chk("compara_ocupado", int'(oc[d]), 1);
    chk("compara_in_listo", int'(il[d]), 0);
    chk("compara_cmp_borrado", int'(cmpv[d]), 0);
    chk("compara_swp_borrado", int'(swpv[d]), 0);
    n = 0;
    while (!ov[d] && n < 64) begin
      tick();
      n++;
    end
    chk("duracion_compara", n, nc);
    chk("comparaciones", int'(cmpv[d]), nc);
    chk("intercambios", int'(swpv[d]), ns);
    chk("entrega_ocupado", int'(oc[d]), 0);
    n = 0;
    stalled = 1'b0;
    while (mon_idx[d] < NT && n < 200) begin
      if (stall && !stalled && mon_idx[d] == 1) begin
        stalled = 1'b1;
        ol[d] = 1'b0;
        v = dout[d];
        repeat (5) begin
          tick();
          chk("espera_dato", int'(dout[d]), int'(v));
          chk("espera_valido", int'(ov[d]), 1);
        end
        chk("espera_j", mon_idx[d], 1);
      end
      ol[d] = ($urandom_range(0, 1) == 1);
      tick();
      n++;
    end
    ol[d] = 1'b0;
    chk("entregas", mon_idx[d], NT);
    chk("fin_in_listo", int'(il[d]), 1);
    chk("fin_out_valido", int'(ov[d]), 0);
    tick();
    chk("fin_cmp_retenido", int'(cmpv[d]), nc);
    chk("fin_swp_retenido", int'(swpv[d]), ns);
    if (has_lit) begin
      for (int e = 0; e < NT; e++) chk("literal_dato", int'(got_s[d][e]), int'(lit[e]));
      chk("literal_cmp", int'(cmpv[d]), lc);
      chk("literal_swp", int'(swpv[d]), ls);
    end
  endtask

  frame_t fr, lit;

  initial begin
    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b0;
      di[d] = '0;
      ol[d] = 1'b0;
      mon_idx[d] = 0;
      hold[d] = 1'b0;
      prevd[d] = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_out_valido", int'(ov[d]), 0);
      chk("rst_ultimo", int'(ul[d]), 0);
      chk("rst_ocupado", int'(oc[d]), 0);
      chk("rst_dato_out", int'(dout[d]), 0);
      chk("rst_cmp", int'(cmpv[d]), 0);
      chk("rst_swp", int'(swpv[d]), 0);
    end
    rst_n = 1'b1;
    tick();
    chk("rst_in_listo0", int'(il[0]), 1);
    chk("rst_in_listo1", int'(il[1]), 1);
    fork
      monitor();
    join_none

    fr = '{8'd40, 8'd5, 8'd35, 8'd22};  lit = '{8'd5, 8'd22, 8'd35, 8'd40};
    run_frame(0, fr, 1'b0, 1'b1, 1'b1, lit, 6, 4);
    fr = '{8'd1, 8'd2, 8'd3, 8'd4};     lit = '{8'd1, 8'd2, 8'd3, 8'd4};
    run_frame(0, fr, 1'b0, 1'b0, 1'b1, lit, 3, 0);
    fr = '{8'd22, 8'd22, 8'd22, 8'd22}; lit = '{8'd22, 8'd22, 8'd22, 8'd22};
    run_frame(0, fr, 1'b0, 1'b1, 1'b1, lit, 3, 0);
    fr = '{8'hFA, 8'h04, 8'h80, 8'h7F}; lit = '{8'h04, 8'h7F, 8'h80, 8'hFA};
    run_frame(0, fr, 1'b0, 1'b0, 1'b1, lit, 6, 4);
    lit = '{8'h80, 8'hFA, 8'h04, 8'h7F};
    run_frame(1, fr, 1'b1, 1'b1, 1'b1, lit, 6, 2);

    // Reset in the middle of sorting 4,3,2,1.
    fr = '{8'd4, 8'd3, 8'd2, 8'd1};
    for (int e = 0; e < NT; e++) begin
      iv[0] = 1'b1;
      di[0] = fr[e];
      tick();
    end
    iv[0] = 1'b0;
    tick();
    chk("pre_rst_ocupado", int'(oc[0]), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valido", int'(ov[0]), 0);
    chk("rst_mid_ultimo", int'(ul[0]), 0);
    chk("rst_mid_ocupado", int'(oc[0]), 0);
    chk("rst_mid_dato_out", int'(dout[0]), 0);
    chk("rst_mid_cmp", int'(cmpv[0]), 0);
    chk("rst_mid_swp", int'(swpv[0]), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("rst_mid_in_listo", int'(il[0]), 1);
    fr = '{8'd9, 8'd8, 8'd7, 8'd6};     lit = '{8'd6, 8'd7, 8'd8, 8'd9};
    run_frame(0, fr, 1'b0, 1'b0, 1'b1, lit, 6, 6);

    for (int r = 0; r < 30; r++) begin
      int d;
      d = r % 2;
      for (int e = 0; e < NT; e++) begin
        if (r % 3 == 0) fr[e] = 8'($urandom_range(0, 3) * 64);
        else            fr[e] = 8'($urandom_range(0, 255));
      end
      run_frame(d, fr, d == 1, ($urandom_range(0, 1) == 1), 1'b0, lit, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ordenador_burbuja.md
ORDENADOR_BURBUJA -- requirements
Module: ordenador_burbuja

Interface
REQ-001 The block SHALL have parameter N, default 4, number of 8-bit entries sorted per frame, legal range 2..8.
REQ-002 The block SHALL have parameter SIGNO, default 0, comparison mode: 0 unsigned, 1 two's-complement signed.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valido  input  1  dato_in holds a value to load.
REQ-007 dato_in  input  8  value to load.
REQ-008 in_listo  output  1  block accepts a load this cycle.
REQ-009 out_valido  output  1  dato_out holds a sorted value.
REQ-010 dato_out  output  8  sorted value, ascending order.
REQ-011 ultimo  output  1  dato_out is the last (largest) entry of the frame.
REQ-012 out_listo  input  1  consumer accepts dato_out this cycle.
REQ-013 ocupado  output  1  high in COMPARA state.
REQ-014 comparaciones  output  6  compare steps in the current/last frame.
REQ-015 intercambios  output  6  swaps in the current/last frame.

Function
REQ-016 FSM states SHALL be CARGA, COMPARA, ENTREGA.
REQ-017 CARGA: in_listo=1; each cycle with in_valido=1 writes dato_in to entry k (k from 0), k increments; after write of entry N-1 -> COMPARA next cycle, comparaciones and intercambios cleared at that edge.
REQ-018 COMPARA: one compare per cycle of entries i and i+1 via the shared comparator; if entry i > entry i+1 (per SIGNO) both entries are swapped at the same edge and intercambios increments; comparaciones increments every compare cycle.
REQ-019 Pass p (from 0) SHALL cover i = 0..N-2-p; at pass end, if the pass made zero swaps or p = N-2 -> ENTREGA, else p+1, i=0.
REQ-020 Equal entries SHALL NOT be swapped (stable sort).
REQ-021 ENTREGA: out_valido=1, dato_out = entry j (from 0); j advances only when out_valido and out_listo both high; ultimo=1 when j = N-1; transfer of j=N-1 -> CARGA, k=0.
REQ-022 dato_out SHALL hold stable while out_valido=1 and out_listo=0.
REQ-023 in_listo SHALL be 0 outside CARGA; out_valido SHALL be 0 outside ENTREGA; in_valido outside CARGA is ignored.
REQ-024 Counters SHALL hold their final values from leaving COMPARA until the next COMPARA entry.
REQ-025 Worst-case COMPARA duration SHALL be N(N-1)/2 cycles; best case N-1 cycles.

Reset
REQ-026 rst_n low SHALL immediately force state CARGA, k=i=j=p=0, in_listo=1 after release, out_valido=0, ultimo=0, ocupado=0, dato_out=0, comparaciones=0, intercambios=0, all entries 0.
REQ-027 Reset asserted mid-load, mid-sort or mid-delivery SHALL discard the frame; first accepted value after release is entry 0.

Structure
REQ-028 A shared package SHALL hold the state encoding (CARGA, COMPARA, ENTREGA), data width 8, and counter width 6.
REQ-029 The compare SHALL be one sub-module instance, comparador8bits (a, b in; igual, mayor, menor out), with operands sign-bit-inverted before it when SIGNO=1; no second comparator.

Verification
REQ-030 Load 40,5,35,22 -> output 5,22,35,40, ultimo on 40, comparaciones=6, intercambios=4.
REQ-031 Load 1,2,3,4 -> output 1,2,3,4, comparaciones=3, intercambios=0 (early exit after pass 0).
REQ-032 Load 22,22,22,22 -> output 22,22,22,22, comparaciones=3, intercambios=0.
REQ-033 Load 0xFA,4,0x80,0x7F: SIGNO=0 -> 4,0x7F,0x80,0xFA; SIGNO=1 -> 0x80,0xFA,4,0x7F.
REQ-034 During ENTREGA hold out_listo=0 for 5 cycles -> dato_out stable, j unchanged, no entry lost or repeated.
REQ-035 Assert rst_n=0 during COMPARA of 4,3,2,1 -> all outputs at reset values; reload 9,8,7,6 -> output 6,7,8,9, comparaciones=6, intercambios=6.
